cjtag_bridge_core: RTL and testbench
====================================

// Module: cjtag_bridge_core
// PURPOSE
//  IEEE 1149.7-style 2-pin cJTAG (TCKC/TMSC) to 4-wire JTAG bridge, OScan1 format only.
//  Oversamples TCKC/TMSC with system clock clk_i (100 MHz).
//  Decodes escape sequences and the activation packet, then converts 3-slot OScan1 packets
//  into TCK/TMS/TDI for a downstream jtag_tap, returning TDO on TMSC.
// PARAMETERS
//  SYNC_STAGES    2   synchronizer depth for tckc_i/tmsc_i (min 2)
//  OAC_OSCAN1     4'hC  activation code accepted
//  EC_OSCAN1      4'h8  extension code accepted
// PORTS
//  clk_i     in   1  system clock; all logic rising-edge
//  ntrst_i   in   1  reset, asynchronous, active-low (also drives the TAP's ntrst)
//  tckc_i    in   1  cJTAG clock from host (asynchronous to clk_i)
//  tmsc_i    in   1  cJTAG data from host (pad input)
//  tmsc_o    out  1  cJTAG data to host (TDO slot)
//  tmsc_oen  out  1  pad output enable, active-low (0 = bridge drives tmsc_o)
//  tck_o     out  1  JTAG TCK to TAP
//  tms_o     out  1  JTAG TMS to TAP
//  tdi_o     out  1  JTAG TDI to TAP
//  tdo_i     in   1  JTAG TDO from TAP
//  online_o  out  1  1 = OScan1 active
//  nsp_o     out  1  1 = standard protocol (offline/inactive); always ~online_o
// BEHAVIOUR
//  Reset values: tck_o=0, tms_o=1, tdi_o=0, tmsc_o=0, tmsc_oen=1, online_o=0, nsp_o=1.
//  Reset state: OFFLINE.
//  Input conditioning:
//   - SYNC_STAGES-FF sync on tckc/tmsc, then edge detect.
//   - Latency input->event = 3 clk.
//   - Requires each TCKC phase >= 4 clk_i.
//  Escape detector (any state):
//   - Counts synced TMSC edges while TCKC is high; count saturates at 15, clears on TCKC rise.
//   - Evaluated on TCKC fall.
//   - 0-3 edges: no escape; a nonzero count is ignored.
//   - 4-5 edges: deselect -> OFFLINE.
//   - 6-7 edges: select -> ACTIVATE; the activation shift register and bit count are cleared.
//   - >=8 edges: reset -> OFFLINE; tms_o=1, tck_o=0, tmsc_oen=1.
//   - An escape overrides any packet in progress. The slot counter is cleared.
//  States:
//   - OFFLINE: outputs at reset values; online_o=0.
//   - ACTIVATE:
//     - Shift 12 bits of TMSC, sampled on TCKC rise, LSB first: OAC[3:0], EC[3:0], CP[3:0].
//     - After the 12th bit: OAC==OAC_OSCAN1 && EC==EC_OSCAN1 -> ONLINE; otherwise -> OFFLINE.
//     - CP value is ignored.
//   - ONLINE: online_o=1, nsp_o=0. A 2-bit slot counter (0,1,2, wrap) advances on each TCKC rise.
//     - Slot0 (nTDI): on TCKC rise, tdi_o <= ~tmsc.
//     - Slot1 (TMS): on TCKC rise, tms_o <= tmsc.
//     - On TCKC fall ending slot1: tmsc_o <= tdo_i, tmsc_oen <= 0.
//     - Slot2 (TDO): on TCKC rise, tck_o <= 1; on TCKC fall ending slot2, tck_o <= 0 and tmsc_oen <= 1.
//     - TMSC edges while tmsc_oen=0 are excluded from the escape count.
//  tck_o is glitch-free, registered, and high for exactly one TCKC high phase per packet.
//  TMS/TDI are stable >= 1 TCKC phase before the tck_o rise.
//  Reset mid-operation: asynchronous return to reset values and state OFFLINE.
// STRUCTURE
//  Package cjtag_pkg:
//   - state_e enum {OFFLINE, ACTIVATE, ONLINE}.
//   - OAC/EC constants.
//   - Escape thresholds ESC_DESEL_MIN=4, ESC_SEL_MIN=6, ESC_RST_MIN=8.
//  Sub-module cjtag_sync: N-stage synchronizer with async active-low reset.
//   - Instantiated twice (tckc, tmsc).
//  Remaining logic (edge detect, escape counter, activation shifter, slot FSM) is in this module.
//  Bench pairs it with jtag_tap (IDCODE 32'h1DEAD3FF, IR_LEN 5), tdo_i <- TAP tdo.
// TESTING
//  1. ntrst_i=0 -> online_o=0, nsp_o=1, tmsc_oen=1, tck_o=0, tms_o=1; hold through TCKC toggling.
//  2. TCKC high + 6 TMSC edges, TCKC low, then bits OAC=C, EC=8, CP=0 -> online_o=1 after the 12th rise.
//  3. Same sequence with OAC=4'h5 -> online_o stays 0; tck_o never pulses.
//  4. Online packets:
//     - Send 5 packets with TMS=1, then TMS=0,1,0,0 -> Shift-DR.
//     - Shift 32 packets; TDO slots read LSB-first give 32'h1DEAD3FF.
//     - Exactly one tck_o pulse per packet.
//  5. Online, TCKC high + 4 TMSC edges -> on TCKC fall online_o=0, nsp_o=1, tmsc_oen=1.
//  6. Online mid-packet (after slot0), 8 edges -> OFFLINE, tms_o=1.
//     - Slot counter restarts at slot0 after re-selection.
//     - Then ntrst_i pulse mid-activation -> OFFLINE.

Source files
------------

// File: rtl/cjtag_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cjtag_pkg
//  Description : Shared types and constants for the cJTAG-to-JTAG bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package cjtag_pkg;

    typedef enum logic [1:0] {
        OFFLINE  = 2'd0,
        ACTIVATE = 2'd1,
        ONLINE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ESC_NONE  = 2'd0,
        ESC_DESEL = 2'd1,
        ESC_SEL   = 2'd2,
        ESC_RST   = 2'd3
    } esc_e;

    localparam logic [3:0] C_OAC_OSCAN1    = 4'hC;
    localparam logic [3:0] C_EC_OSCAN1     = 4'h8;

    localparam logic [3:0] ESC_DESEL_MIN   = 4'd4;
    localparam logic [3:0] ESC_SEL_MIN     = 4'd6;
    localparam logic [3:0] ESC_RST_MIN     = 4'd8;

    localparam int         SYNC_MIN_STAGES = 2;
    localparam int         ACT_BITS        = 12;

    // Counts below the deselect threshold are not escapes and are ignored.
    function automatic esc_e esc_classify(input logic [3:0] cnt);
        esc_e res;
        if (cnt >= ESC_RST_MIN) begin
            res = ESC_RST;
        end else if (cnt >= ESC_SEL_MIN) begin
            res = ESC_SEL;
        end else if (cnt >= ESC_DESEL_MIN) begin
            res = ESC_DESEL;
        end else begin
            res = ESC_NONE;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cjtag_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cjtag_sync
//  Description : N-stage flop synchronizer with asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module cjtag_sync
    import cjtag_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    localparam int DEPTH = (STAGES < SYNC_MIN_STAGES) ? SYNC_MIN_STAGES : STAGES;

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cjtag_bridge_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cjtag_bridge_core
//  Description : 2-pin cJTAG (OScan1) to 4-wire JTAG bridge, oversampled by clk_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module cjtag_bridge_core
    import cjtag_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] OAC_OSCAN1  = C_OAC_OSCAN1,
    parameter logic [3:0] EC_OSCAN1   = C_EC_OSCAN1
) (
    input  logic clk_i,
    input  logic ntrst_i,
    input  logic tckc_i,
    input  logic tmsc_i,
    output logic tmsc_o,
    output logic tmsc_oen,
    output logic tck_o,
    output logic tms_o,
    output logic tdi_o,
    input  logic tdo_i,
    output logic online_o,
    output logic nsp_o
);

    logic tckc_s;
    logic tmsc_s;

    cjtag_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_tckc (
        .clk_i  (clk_i),
        .rst_ni (ntrst_i),
        .d_i    (tckc_i),
        .q_o    (tckc_s)
    );

    cjtag_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_tmsc (
        .clk_i  (clk_i),
        .rst_ni (ntrst_i),
        .d_i    (tmsc_i),
        .q_o    (tmsc_s)
    );

    state_e                state_q,    state_d;
    logic                  tckc_prev_q;
    logic                  tmsc_prev_q;
    logic [3:0]            esc_cnt_q,  esc_cnt_d;
    logic [ACT_BITS-1:0]   act_sr_q,   act_sr_d;
    logic [3:0]            act_cnt_q,  act_cnt_d;
    logic [1:0]            slot_q,     slot_d;
    logic                  tck_q,      tck_d;
    logic                  tms_q,      tms_d;
    logic                  tdi_q,      tdi_d;
    logic                  tmsc_out_q, tmsc_out_d;
    logic                  oen_q,      oen_d;

    logic                  w_tckc_rise;
    logic                  w_tckc_fall;
    logic                  w_tmsc_edge;
    esc_e                  w_esc;
    logic [ACT_BITS-1:0]   w_act_shift;

    assign w_tckc_rise = tckc_s & ~tckc_prev_q;
    assign w_tckc_fall = ~tckc_s & tckc_prev_q;
    assign w_tmsc_edge = tmsc_s ^ tmsc_prev_q;
    assign w_esc       = esc_classify(esc_cnt_q);
    assign w_act_shift = {tmsc_s, act_sr_q[ACT_BITS-1:1]};

    always_ff @(posedge clk_i or negedge ntrst_i) begin
        if (!ntrst_i) begin
            state_q     <= OFFLINE;
            tckc_prev_q <= 1'b0;
            tmsc_prev_q <= 1'b0;
            esc_cnt_q   <= 4'd0;
            act_sr_q    <= '0;
            act_cnt_q   <= 4'd0;
            slot_q      <= 2'd0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            tmsc_out_q  <= 1'b0;
            oen_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            tckc_prev_q <= tckc_s;
            tmsc_prev_q <= tmsc_s;
            esc_cnt_q   <= esc_cnt_d;
            act_sr_q    <= act_sr_d;
            act_cnt_q   <= act_cnt_d;
            slot_q      <= slot_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            tmsc_out_q  <= tmsc_out_d;
            oen_q       <= oen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        esc_cnt_d  = esc_cnt_q;
        act_sr_d   = act_sr_q;
        act_cnt_d  = act_cnt_q;
        slot_d     = slot_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        tmsc_out_d = tmsc_out_q;
        oen_d      = oen_q;

        // Edges the bridge itself causes while driving the pad must not look like escapes.
        if (w_tckc_rise) begin
            esc_cnt_d = 4'd0;
        end else if (tckc_s && w_tmsc_edge && oen_q && (esc_cnt_q != 4'hF)) begin
            esc_cnt_d = esc_cnt_q + 4'd1;
        end

        if (w_tckc_fall && (w_esc != ESC_NONE)) begin
            slot_d     = 2'd0;
            tck_d      = 1'b0;
            tms_d      = 1'b1;
            tdi_d      = 1'b0;
            tmsc_out_d = 1'b0;
            oen_d      = 1'b1;
            act_sr_d   = '0;
            act_cnt_d  = 4'd0;
            state_d    = (w_esc == ESC_SEL) ? ACTIVATE : OFFLINE;
        end else begin
            unique case (state_q)
                OFFLINE: begin
                    state_d = OFFLINE;
                end
                ACTIVATE: begin
                    if (w_tckc_rise) begin
                        act_sr_d  = w_act_shift;
                        act_cnt_d = act_cnt_q + 4'd1;
                        if (act_cnt_q == 4'(ACT_BITS - 1)) begin
                            act_cnt_d = 4'd0;
                            slot_d    = 2'd0;
                            if ((w_act_shift[3:0] == OAC_OSCAN1) &&
                                (w_act_shift[7:4] == EC_OSCAN1)) begin
                                state_d = ONLINE;
                            end else begin
                                state_d = OFFLINE;
                            end
                        end
                    end
                end
                ONLINE: begin
                    if (w_tckc_rise) begin
                        unique case (slot_q)
                            2'd0: begin
                                tdi_d  = ~tmsc_s;
                                slot_d = 2'd1;
                            end
                            2'd1: begin
                                tms_d  = tmsc_s;
                                slot_d = 2'd2;
                            end
                            default: begin
                                tck_d  = 1'b1;
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                    // slot_q already points at the next slot, so 2 means slot1 just ended.
                    if (w_tckc_fall) begin
                        if (slot_q == 2'd2) begin
                            tmsc_out_d = tdo_i;
                            oen_d      = 1'b0;
                        end else if (slot_q == 2'd0) begin
                            tck_d = 1'b0;
                            oen_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = OFFLINE;
                end
            endcase
        end
    end

    assign tck_o    = tck_q;
    assign tms_o    = tms_q;
    assign tdi_o    = tdi_q;
    assign tmsc_o   = tmsc_out_q;
    assign tmsc_oen = oen_q;
    assign online_o = (state_q == ONLINE);
    assign nsp_o    = ~(state_q == ONLINE);

endmodule
`default_nettype wire

// File: tb/tb_cjtag_bridge_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cjtag_bridge_core
//  Description : Directed bench for cjtag_bridge_core with a behavioural JTAG TAP.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cjtag_bridge_core;

    localparam int          PH     = 80;
    localparam int          HP     = 40;
    localparam logic [31:0] IDCODE = 32'h1DEAD3FF;

    logic clk       = 1'b0;
    logic ntrst     = 1'b1;
    logic tckc      = 1'b0;
    logic host_tmsc = 1'b0;
    logic tmsc_pad;
    logic tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, tdo, online, nsp;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    assign tmsc_pad = tmsc_oen ? host_tmsc : tmsc_o;

    always #5 clk = ~clk;

    cjtag_bridge_core #(
        .SYNC_STAGES (2),
        .OAC_OSCAN1  (4'hC),
        .EC_OSCAN1   (4'h8)
    ) dut (
        .clk_i    (clk),
        .ntrst_i  (ntrst),
        .tckc_i   (tckc),
        .tmsc_i   (tmsc_pad),
        .tmsc_o   (tmsc_o),
        .tmsc_oen (tmsc_oen),
        .tck_o    (tck_o),
        .tms_o    (tms_o),
        .tdi_o    (tdi_o),
        .tdo_i    (tdo),
        .online_o (online),
        .nsp_o    (nsp)
    );

    // Behavioural TAP: IDCODE in DR at capture, 5-bit IR.
    localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SELDR = 4'd2, CAPDR = 4'd3,
                           SHDR = 4'd4, EX1DR = 4'd5, PADR = 4'd6, EX2DR = 4'd7,
                           UPDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
                           EX1IR = 4'd12, PAIR = 4'd13, EX2IR = 4'd14, UPIR = 4'd15;
    logic [3:0]  tap_st;
    logic [31:0] tap_dr;
    logic [4:0]  tap_ir;

    always @(posedge tck_o or negedge ntrst) begin
        if (!ntrst) begin
            tap_st <= TLR;
            tap_dr <= '0;
            tap_ir <= 5'b00001;
        end else begin
            if (tap_st == CAPDR) tap_dr <= IDCODE;
            if (tap_st == SHDR)  tap_dr <= {tdi_o, tap_dr[31:1]};
            if (tap_st == CAPIR) tap_ir <= 5'b00001;
            if (tap_st == SHIR)  tap_ir <= {tdi_o, tap_ir[4:1]};
            case (tap_st)
                TLR:     tap_st <= tms_o ? TLR   : RTI;
                RTI:     tap_st <= tms_o ? SELDR : RTI;
                SELDR:   tap_st <= tms_o ? SELIR : CAPDR;
                CAPDR:   tap_st <= tms_o ? EX1DR : SHDR;
                SHDR:    tap_st <= tms_o ? EX1DR : SHDR;
                EX1DR:   tap_st <= tms_o ? UPDR  : PADR;
                PADR:    tap_st <= tms_o ? EX2DR : PADR;
                EX2DR:   tap_st <= tms_o ? UPDR  : SHDR;
                UPDR:    tap_st <= tms_o ? SELDR : RTI;
                SELIR:   tap_st <= tms_o ? TLR   : CAPIR;
                CAPIR:   tap_st <= tms_o ? EX1IR : SHIR;
                SHIR:    tap_st <= tms_o ? EX1IR : SHIR;
                EX1IR:   tap_st <= tms_o ? UPIR  : PAIR;
                PAIR:    tap_st <= tms_o ? EX2IR : PAIR;
                EX2IR:   tap_st <= tms_o ? UPIR  : SHIR;
                default: tap_st <= tms_o ? SELDR : RTI;
            endcase
        end
    end

    assign tdo = (tap_st == SHDR) ? tap_dr[0] : ((tap_st == SHIR) ? tap_ir[0] : 1'b0);

    always @(posedge tck_o) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TCKC period carrying bit b, data changed mid low phase.
    task automatic cycle(input logic b);
        #(HP) host_tmsc = b;
        #(HP) tckc = 1'b1;
        #(PH) tckc = 1'b0;
    endtask

    task automatic escape(input int n);
        #(PH) tckc = 1'b1;
        #(HP);
        for (int i = 0; i < n; i++) begin
            host_tmsc = ~host_tmsc;
            #(HP);
        end
        tckc = 1'b0;
        #(HP);
    endtask

    task automatic activate(input logic [11:0] bits, input string tag, input logic exp_on);
        escape(6);
        for (int i = 0; i < 11; i++) cycle(bits[i]);
        check({tag, "_pre12"}, {31'd0, online}, 32'd0);
        cycle(bits[11]);
        check({tag, "_online"}, {31'd0, online}, {31'd0, exp_on});
    endtask

    task automatic packet(input logic tdi_v, input logic tms_v, output logic tdo_v);
        int p0;
        p0 = pulses;
        cycle(~tdi_v);
        cycle(tms_v);
        #(PH) tckc = 1'b1;
        #(HP);
        tdo_v = tmsc_o;
        check("oen_slot2", {31'd0, tmsc_oen}, 32'd0);
        #(HP) tckc = 1'b0;
        check("tck_pulse_per_pkt", pulses - p0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic        b;
        logic [31:0] id;
        int          p0;

        // Reset and hold through TCKC activity
        #2 ntrst = 1'b0;
        #30;
        check("rst_online", {31'd0, online},   32'd0);
        check("rst_nsp",    {31'd0, nsp},      32'd1);
        check("rst_oen",    {31'd0, tmsc_oen}, 32'd1);
        check("rst_tck",    {31'd0, tck_o},    32'd0);
        check("rst_tms",    {31'd0, tms_o},    32'd1);
        check("rst_tdi",    {31'd0, tdi_o},    32'd0);
        check("rst_tmsc_o", {31'd0, tmsc_o},   32'd0);
        escape(6);
        for (int i = 0; i < 12; i++) cycle(1'b0);
        check("rst_hold_online", {31'd0, online},   32'd0);
        check("rst_hold_oen",    {31'd0, tmsc_oen}, 32'd1);
        check("rst_hold_tms",    {31'd0, tms_o},    32'd1);
        ntrst = 1'b1;
        #(PH);

        // Wrong OAC: stays offline, no TCK
        p0 = pulses;
        activate(12'h085, "bad_oac", 1'b0);
        for (int i = 0; i < 6; i++) cycle(i[0]);
        check("bad_oac_no_tck", pulses - p0, 32'd0);
        check("bad_oac_nsp",    {31'd0, nsp}, 32'd1);

        // Valid activation
        activate(12'h08C, "act", 1'b1);
        check("act_nsp", {31'd0, nsp}, 32'd0);

        // Navigate TAP to Shift-DR then read IDCODE
        p0 = pulses;
        for (int i = 0; i < 5; i++) packet(1'b0, 1'b1, b);
        packet(1'b0, 1'b0, b);
        packet(1'b0, 1'b1, b);
        packet(1'b0, 1'b0, b);
        packet(1'b0, 1'b0, b);
        id = '0;
        for (int i = 0; i < 32; i++) begin
            packet(1'b0, 1'b0, b);
            id[i] = b;
        end
        check("idcode",       id, 32'h1DEAD3FF);
        check("pulse_total",  pulses - p0, 32'd41);
        check("shift_tms",    {31'd0, tms_o}, 32'd0);
        check("shift_tdi",    {31'd0, tdi_o}, 32'd0);
        packet(1'b1, 1'b1, b);
        check("pkt_tdi1", {31'd0, tdi_o}, 32'd1);
        check("pkt_tms1", {31'd0, tms_o}, 32'd1);

        // Deselect escape
        check("pre_desel_online", {31'd0, online}, 32'd1);
        escape(4);
        check("desel_online", {31'd0, online},   32'd0);
        check("desel_nsp",    {31'd0, nsp},      32'd1);
        check("desel_oen",    {31'd0, tmsc_oen}, 32'd1);

        // Reset escape mid-packet, then reselect and realign slots
        activate(12'h08C, "act2", 1'b1);
        cycle(1'b1);
        escape(8);
        check("escrst_online", {31'd0, online},   32'd0);
        check("escrst_tms",    {31'd0, tms_o},    32'd1);
        check("escrst_tck",    {31'd0, tck_o},    32'd0);
        check("escrst_oen",    {31'd0, tmsc_oen}, 32'd1);
        activate(12'h08C, "act3", 1'b1);
        packet(1'b1, 1'b0, b);
        check("realign_tdi", {31'd0, tdi_o}, 32'd1);
        check("realign_tms", {31'd0, tms_o}, 32'd0);

        // Hardware reset in the middle of activation
        escape(4);
        escape(6);
        for (int i = 0; i < 6; i++) cycle(i < 2 ? 1'b0 : 1'b1);
        ntrst = 1'b0;
        #20;
        check("ntrst_mid_online", {31'd0, online}, 32'd0);
        check("ntrst_mid_tms",    {31'd0, tms_o},  32'd1);
        ntrst = 1'b1;
        #(HP);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        check("ntrst_after_online", {31'd0, online}, 32'd0);
        check("ntrst_after_nsp",    {31'd0, nsp},    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
